// File: rtl/pkt_xform_ctrl.sv
// Bus-programmable packet pass-through: per-packet transform (pass/invert/xor/drop)
// into a LAT-deep rx->tx pipeline, with packet/beat counters on the register bus.
module pkt_xform_ctrl #(
  parameter int          DW        = 8,
  parameter int          LAT       = 1,
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_cmd_valid,
  input  logic          bus_op,
  input  logic [15:0]   bus_addr,
  input  logic [15:0]   bus_wr_data,
  output logic [15:0]   bus_rd_data,
  input  logic [DW-1:0] rxd,
  input  logic          rx_dv,
  output logic [DW-1:0] txd,
  output logic          tx_en
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t        state, next_state;
  logic [15:0]   offset;
  logic          in_range, wr, rd;
  logic          wr_ctrl, wr_key, wr_hi, wr_lo, wr_beat, rd_hi;
  logic [1:0]    mode, active_mode, cur_mode;
  logic          cnt_en;
  logic [DW-1:0] key;
  logic [15:0]   key_ext;
  logic [31:0]   pkt_cnt;
  logic [15:0]   lo_shadow, beat_cnt;
  logic          start;
  logic [DW-1:0] xf_d;
  logic          xf_v;
  logic [DW-1:0] pipe_d [LAT];
  logic [LAT-1:0] pipe_v;

  assign offset   = bus_addr - BASE_ADDR;
  assign in_range = offset < 16'd6;
  assign wr       = bus_cmd_valid & bus_op & in_range;
  assign rd       = bus_cmd_valid & ~bus_op & in_range;
  assign wr_ctrl  = wr & (offset[2:0] == 3'd0);
  assign wr_key   = wr & (offset[2:0] == 3'd1);
  assign wr_hi    = wr & (offset[2:0] == 3'd2);
  assign wr_lo    = wr & (offset[2:0] == 3'd3);
  assign wr_beat  = wr & (offset[2:0] == 3'd4);
  assign rd_hi    = rd & (offset[2:0] == 3'd2);
  assign start    = (state == IDLE) & rx_dv;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rx_dv)  next_state = IN_PKT;
      IN_PKT:  if (!rx_dv) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The first beat of a packet sees CTRL.mode directly; later beats use the latched copy.
  always_comb begin
    cur_mode = (state == IN_PKT) ? active_mode : mode;
    xf_d     = '0;
    xf_v     = 1'b0;
    if (rx_dv) begin
      case (cur_mode)
        2'd0:    begin xf_d = rxd;       xf_v = 1'b1; end
        2'd1:    begin xf_d = ~rxd;      xf_v = 1'b1; end
        2'd2:    begin xf_d = rxd ^ key; xf_v = 1'b1; end
        default: begin xf_d = '0;        xf_v = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode        <= 2'd0;
      cnt_en      <= 1'b1;
      key         <= '0;
      active_mode <= 2'd0;
    end else begin
      if (start)   active_mode <= mode;
      if (wr_ctrl) {cnt_en, mode} <= bus_wr_data[2:0];
      if (wr_key)  key <= bus_wr_data[DW-1:0];
    end
  end

  // A bus write to a counter in the same cycle as an increment discards the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      lo_shadow <= '0;
      beat_cnt  <= '0;
    end else begin
      if (wr_hi) pkt_cnt[31:16] <= bus_wr_data;
      if (wr_lo) pkt_cnt[15:0]  <= bus_wr_data;
      if (!wr_hi && !wr_lo && start && cnt_en) pkt_cnt <= pkt_cnt + 32'd1;
      if (wr_beat)                             beat_cnt <= bus_wr_data;
      else if (rx_dv && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
      if (rd_hi) lo_shadow <= pkt_cnt[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe_d[i] <= '0;
      pipe_v <= '0;
    end else begin
      pipe_d[0] <= xf_d;
      pipe_v[0] <= xf_v;
      for (int i = 1; i < LAT; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  assign txd   = pipe_d[LAT-1];
  assign tx_en = pipe_v[LAT-1];

  always_comb begin
    key_ext         = '0;
    key_ext[DW-1:0] = key;
  end

  always_comb begin
    bus_rd_data = '0;
    if (rd) begin
      case (offset[2:0])
        3'd0:    bus_rd_data = {13'd0, cnt_en, mode};
        3'd1:    bus_rd_data = key_ext;
        3'd2:    bus_rd_data = pkt_cnt[31:16];
        3'd3:    bus_rd_data = lo_shadow;
        3'd4:    bus_rd_data = beat_cnt;
        3'd5:    bus_rd_data = {13'd0, active_mode, state == IN_PKT};
        default: bus_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_xform_ctrl.sv
// Self-checking bench: two instances (LAT=2 and LAT=4) share stimulus and are
// compared every cycle against a packet-level reference model.
module tb_pkt_xform_ctrl;

  localparam int          DW   = 8;
  localparam logic [15:0] BASE = 16'h0010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bus_cmd_valid, bus_op;
  logic [15:0]   bus_addr, bus_wr_data;
  logic [DW-1:0] rxd;
  logic          rx_dv;
  logic [15:0]   rd2, rd4;
  logic [DW-1:0] txd2, txd4;
  logic          tx_en2, tx_en4;

  pkt_xform_ctrl #(.DW(DW), .LAT(2), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(rd2),
    .rxd(rxd), .rx_dv(rx_dv), .txd(txd2), .tx_en(tx_en2));

  pkt_xform_ctrl #(.DW(DW), .LAT(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(rd4),
    .rxd(rxd), .rx_dv(rx_dv), .txd(txd4), .tx_en(tx_en4));

  always #5 clk = ~clk;

  // Reference model state: registers as the programmer sees them, plus
  // a history of transformed beats (index 0 = newest) for the tx side.
  logic [1:0]    m_mode, m_active;
  logic          m_cnt_en, m_in_pkt;
  logic [DW-1:0] m_key;
  logic [31:0]   m_pkt;
  logic [15:0]   m_shadow, m_beat;
  logic [DW-1:0] h_d [8];
  logic          h_v [8];
  int            checks = 0;
  int            failures = 0;

  function automatic logic [15:0] model_read();
    logic [15:0] off;
    off = bus_addr - BASE;
    if (!(bus_cmd_valid && !bus_op)) return 16'h0000;
    case (off)
      16'd0:   return {13'd0, m_cnt_en, m_mode};
      16'd1:   return {8'd0, m_key};
      16'd2:   return m_pkt[31:16];
      16'd3:   return m_shadow;
      16'd4:   return m_beat;
      16'd5:   return {13'd0, m_active, m_in_pkt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_posedge();
    logic [15:0]   off;
    logic          wr, start;
    logic [1:0]    mode_now;
    logic [DW-1:0] nd;
    logic          nv;
    if (rst_n === 1'b0) begin
      m_mode = 2'd0; m_cnt_en = 1'b1; m_key = '0; m_pkt = '0;
      m_shadow = '0; m_beat = '0; m_in_pkt = 1'b0; m_active = 2'd0;
      for (int i = 0; i < 8; i++) begin h_d[i] = '0; h_v[i] = 1'b0; end
      return;
    end
    off      = bus_addr - BASE;
    wr       = bus_cmd_valid && bus_op;
    start    = !m_in_pkt && rx_dv;
    mode_now = m_in_pkt ? m_active : m_mode;
    nd = '0;
    nv = 1'b0;
    if (rx_dv && mode_now != 2'd3) begin
      nv = 1'b1;
      nd = (mode_now == 2'd0) ? rxd : (mode_now == 2'd1) ? ~rxd : (rxd ^ m_key);
    end
    for (int i = 7; i > 0; i--) begin h_d[i] = h_d[i-1]; h_v[i] = h_v[i-1]; end
    h_d[0] = nd;
    h_v[0] = nv;
    if (bus_cmd_valid && !bus_op && off == 16'd2) m_shadow = m_pkt[15:0];
    if (wr && off == 16'd2)      m_pkt[31:16] = bus_wr_data;
    else if (wr && off == 16'd3) m_pkt[15:0] = bus_wr_data;
    else if (start && m_cnt_en)  m_pkt = m_pkt + 1;
    if (wr && off == 16'd4)                  m_beat = bus_wr_data;
    else if (rx_dv && m_beat != 16'hFFFF)    m_beat = m_beat + 1;
    if (start) m_active = m_mode;
    m_in_pkt = rx_dv;
    if (wr && off == 16'd0) {m_cnt_en, m_mode} = bus_wr_data[2:0];
    if (wr && off == 16'd1) m_key = bus_wr_data[DW-1:0];
  endtask

  task automatic check_output();
    check("txd_lat2",   {8'd0, txd2},   {8'd0, h_d[1]});
    check("tx_en_lat2", {15'd0, tx_en2}, {15'd0, h_v[1]});
    check("txd_lat4",   {8'd0, txd4},   {8'd0, h_d[3]});
    check("tx_en_lat4", {15'd0, tx_en4}, {15'd0, h_v[3]});
  endtask

  // One clock cycle: drive, check combinational read data, clock, check tx.
  task automatic apply_stimulus(input logic [DW-1:0] d, input logic dv, input logic cv,
                                input logic op, input logic [15:0] addr, input logic [15:0] wd);
    rxd = d; rx_dv = dv; bus_cmd_valid = cv; bus_op = op; bus_addr = addr; bus_wr_data = wd;
    #1;
    check("rd_data_lat2", rd2, model_read());
    check("rd_data_lat4", rd4, model_read());
    @(posedge clk);
    model_posedge();
    @(negedge clk);
    check_output();
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [15:0] data);
    apply_stimulus('0, 1'b0, 1'b1, 1'b1, BASE + {13'd0, off}, data);
  endtask

  task automatic bus_read(input logic [2:0] off);
    apply_stimulus('0, 1'b0, 1'b1, 1'b0, BASE + {13'd0, off}, 16'h0);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    apply_stimulus(d, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus('0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 6; i++) bus_read(i[2:0]);
  endtask

  initial begin
    rst_n = 1'b0; rxd = '0; rx_dv = 1'b0; bus_cmd_valid = 1'b0; bus_op = 1'b0;
    bus_addr = '0; bus_wr_data = '0;
    @(posedge clk);
    model_posedge();
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;

    // Reset values of every register and of the tx side
    read_all();
    check("ctrl_reset_const", rd2, 16'h0000);

    // Pass mode, 3-beat packet, then counters
    beat(8'hA5); beat(8'h3C); beat(8'hFF);
    idle(4);
    bus_read(3'd2); bus_read(3'd3); bus_read(3'd4); bus_read(3'd5);

    // XOR with key, then a mid-packet mode change that must not apply until the next packet
    bus_write(3'd1, 16'h000F);
    bus_write(3'd0, 16'h0006);
    beat(8'h5A); idle(4);
    beat(8'h5A);
    apply_stimulus(8'h5A, 1'b1, 1'b1, 1'b1, BASE, 16'h0005);
    beat(8'h5A); idle(4);
    beat(8'h5A); idle(4);
    read_all();

    // 32-bit wrap, then a HI write colliding with a packet start
    bus_write(3'd2, 16'hFFFF); bus_write(3'd3, 16'hFFFF);
    beat(8'h11); idle(1);
    bus_read(3'd2); bus_read(3'd3);
    apply_stimulus(8'h22, 1'b1, 1'b1, 1'b1, BASE + 16'd2, 16'h0001);
    beat(8'h33); idle(3);
    bus_read(3'd2); bus_read(3'd3);

    // Drop mode, then beat counter saturation
    bus_write(3'd0, 16'h0007);
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04); idle(4);
    read_all();
    bus_write(3'd4, 16'hFFFE);
    bus_write(3'd0, 16'h0004);
    beat(8'hC1); beat(8'hC2); beat(8'hC3); idle(4);
    bus_read(3'd4);

    // Reset mid-packet, release with rx_dv still high
    beat(8'h10); beat(8'h20);
    rst_n = 1'b0;
    beat(8'h30);
    bus_read(3'd5);
    beat(8'h40);
    rst_n = 1'b1;
    beat(8'h50); beat(8'h60); idle(4);
    bus_read(3'd2); bus_read(3'd3); read_all();

    // Out-of-range addresses are ignored
    apply_stimulus('0, 1'b0, 1'b1, 1'b1, BASE + 16'd6, 16'hFFFF);
    apply_stimulus('0, 1'b0, 1'b1, 1'b1, BASE - 16'd1, 16'hFFFF);
    apply_stimulus('0, 1'b0, 1'b1, 1'b0, BASE + 16'd7, 16'h0);
    read_all();

    // Randomized traffic and bus activity
    for (int i = 0; i < 600; i++) begin
      logic        dv, cv, op;
      logic [15:0] addr;
      dv   = ($urandom_range(0, 3) != 0);
      cv   = ($urandom_range(0, 3) == 0);
      op   = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
      apply_stimulus(8'($urandom), dv, cv, op, addr, 16'($urandom));
    end
    idle(4);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_xform_ctrl.md
Name: pkt_xform_ctrl

Overview:
- Parametrised successor of the single-channel bus-programmable packet pass-through.
- Forwards an rx stream (rxd/rx_dv) to tx (txd/tx_en) through a LAT-stage pipeline, applying a per-packet transform mode: pass, invert, XOR-key or drop.
- Exposes control, key, packet counter, beat counter and status on the shared 16-bit register bus at BASE_ADDR.

Parameters:
- DW, 8, data width of rxd/txd; legal 1..16.
- LAT, 1, pipeline depth rx->tx in cycles; legal 1..4.
- BASE_ADDR, 16'h0010, bus address of register offset 0.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, synchronous active-low reset, named clk and rst_n as elsewhere in the codebase.
- bus_cmd_valid  input  1  bus command strobe, single cycle.
- bus_op  input  1  1 = write, 0 = read.
- bus_addr  input  16  bus address.
- bus_wr_data  input  16  write data.
- bus_rd_data  output  16  read data, combinational.
- rxd  input  DW  receive data.
- rx_dv  input  1  receive data valid, high for the whole packet.
- txd  output  DW  transmit data.
- tx_en  output  1  transmit enable.

Behaviour:
- Register map; offset = bus_addr - BASE_ADDR. Any address outside BASE_ADDR..BASE_ADDR+5 is ignored by this block.
  - 0 CTRL, RW, reset 16'h0004. [1:0] mode: 0 pass, 1 invert, 2 xor KEY, 3 drop. [2] cnt_en. Other bits read 0.
  - 1 KEY, RW, reset 0. Bits [DW-1:0] are used; upper bits read 0.
  - 2 PKT_HI, RW: pkt_cnt[31:16].
  - 3 PKT_LO, RW: write sets pkt_cnt[15:0]; read returns the shadow.
  - 4 BEAT_CNT, RW, reset 0: 16-bit count of rx_dv-high cycles, saturating at 16'hFFFF.
  - 5 STATUS, RO: [0] in_pkt; [2:1] active_mode.
- Writes take effect at the posedge where bus_cmd_valid & bus_op are high.
- Reads: bus_rd_data is valid in the same cycle when bus_cmd_valid & !bus_op; otherwise it is 16'h0. Unmapped offsets read 0.
- Snapshot: reading PKT_HI loads lo_shadow <= pkt_cnt[15:0] at that posedge. A PKT_LO read returns lo_shadow, so HI-then-LO gives a coherent 32-bit value. lo_shadow resets to 0.
- Packet FSM, states IDLE and IN_PKT:
  - IDLE -> IN_PKT when rx_dv=1. On this transition, active_mode <= CTRL.mode, and pkt_cnt increments if cnt_en=1.
  - IN_PKT -> IDLE when rx_dv=0.
  - A one-cycle rx_dv pulse is a full packet.
- Mode changes written mid-packet do not affect the current packet; they apply from the next IDLE->IN_PKT transition.
- Transform, using the current beat's mode (active_mode, or CTRL.mode on the first beat):
  - pass: d = rxd.
  - invert: d = ~rxd.
  - xor: d = rxd ^ KEY[DW-1:0].
  - drop: valid forced to 0, d = 0.
- Pipeline: {d, valid} passes through LAT registers, so txd/tx_en equal the transform of rxd/rx_dv exactly LAT cycles earlier. While valid is 0, data stages load 0.
- pkt_cnt is 32-bit and wraps from FFFF_FFFF to 0. Dropped packets still count.
- BEAT_CNT increments on every rx_dv=1 cycle, including drop mode, and holds at FFFF.
- Simultaneous events:
  - A bus write to PKT_HI/PKT_LO/BEAT_CNT in the same cycle as an increment: the write wins and that increment is lost.
  - KEY written mid-packet takes effect on the next beat.
- Reset (rst_n=0 at a posedge, including mid-packet): all registers go to their reset values, FSM to IDLE, active_mode to 0, all pipeline stages to 0, so txd=0 and tx_en=0 on the following cycle. The packet in progress when reset releases (rx_dv already 1) counts as a new packet.

Test Plan:
- Reset, then read CTRL, KEY, PKT_HI, PKT_LO, BEAT_CNT, STATUS -> 0004, 0000, 0000, 0000, 0000, 0000; txd=0, tx_en=0.
- LAT=2, DW=8, mode=0, send 3-beat packet A5,3C,FF -> txd A5,3C,FF with tx_en high exactly 2 cycles after each rx beat. Then PKT_LO=1, BEAT_CNT=3.
- Write KEY=0x0F, CTRL=0x0006, send 5A -> txd 55. Write CTRL=0x0005 on packet beat 2 of 3 -> whole packet stays XOR; next packet 5A -> A5.
- Write PKT_HI=FFFF, PKT_LO=FFFF, send one packet -> read HI=0000, LO=0000 (wrap). Write HI=0001 in the same cycle as a packet start -> HI reads 0001, LO unchanged.
- Mode 3, send 4-beat packet -> tx_en stays 0, txd stays 0; PKT count +1, BEAT_CNT +4. Preload BEAT_CNT=FFFE, send 3 beats -> FFFF.
- Assert rst_n=0 mid-packet with LAT=4 -> next cycle txd=0, tx_en=0, STATUS=0. Release reset with rx_dv still high -> PKT_LO=1.
